pe_mac_array: RTL and testbench
===============================

PE_MAC_ARRAY -- requirements
Module: pe_mac_array

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 16, signed operand and output width.
REQ-002 SHALL have parameter WIDTH_ACC, default 32, signed accumulator width; legal only if >= 2*WIDTH_DATA.
REQ-003 SHALL have parameter NUM_LANES, default 4, number of parallel MAC lanes.
REQ-004 SHALL have parameter FRAC_BITS, default 8, arithmetic right shift applied when formatting.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start_i  input  1  pulse that begins a job; sampled only in IDLE.
REQ-008 SHALL have port len_i  input  16  beats per job, sampled with start_i.
REQ-009 SHALL have port in_valid_i  input  1  operand beat valid.
REQ-010 SHALL have port in_ready_o  output  1  beat accepted when in_valid_i && in_ready_o.
REQ-011 SHALL have port a_data_i  input  NUM_LANES*WIDTH_DATA  per-lane operand A; lane n at bits [n*WIDTH_DATA +: WIDTH_DATA].
REQ-012 SHALL have port b_data_i  input  WIDTH_DATA  operand B, broadcast to all lanes.
REQ-013 SHALL have port out_valid_o  output  1  result valid.
REQ-014 SHALL have port out_ready_i  input  1  result consumed when out_valid_o && out_ready_i.
REQ-015 SHALL have port out_data_o  output  WIDTH_DATA  formatted lane result.
REQ-016 SHALL have port out_lane_o  output  $clog2(NUM_LANES) (min 1)  lane index of out_data_o.
REQ-017 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, FORMAT, DRAIN.
REQ-019 IDLE: start_i with len_i!=0 SHALL clear all accumulators, load beat counter, go to RUN; start_i with len_i==0 SHALL clear accumulators and go to FLUSH.
REQ-020 RUN: in_ready_o SHALL be 1; each accepted beat SHALL register per-lane signed product a*b (stage 1), added to the lane accumulator the following cycle (stage 2).
REQ-021 RUN SHALL go to FLUSH on the cycle the len_i-th beat is accepted; in_ready_o SHALL be 0 outside RUN.
REQ-022 FLUSH SHALL last exactly one cycle so the final product is accumulated, then go to FORMAT.
REQ-023 FORMAT SHALL last one cycle and latch, per lane, acc >>> FRAC_BITS reduced to WIDTH_DATA (rule REQ-033), then go to DRAIN.
REQ-024 DRAIN SHALL present lanes 0..NUM_LANES-1 in order with out_valid_o=1; lane index advances only on handshake.
REQ-025 out_data_o and out_lane_o SHALL be held stable while out_valid_o && !out_ready_i.
REQ-026 Handshake on lane NUM_LANES-1 SHALL return to IDLE next cycle with out_valid_o=0.
REQ-027 start_i outside IDLE SHALL be ignored; in_valid_i outside RUN SHALL be ignored.
REQ-028 Accumulation SHALL wrap modulo 2^WIDTH_ACC; no overflow flag.
REQ-029 Minimum job latency from start_i to first out_valid_o SHALL be len_i + 3 cycles with in_valid_i held high.

Reset
REQ-030 rst high SHALL immediately force state IDLE, all accumulators/products/counters/output registers 0, in_ready_o=0, out_valid_o=0, busy_o=0, out_data_o=0, out_lane_o=0.
REQ-031 Reset mid-job SHALL discard the job; first start_i after release SHALL behave as from power-up.

Configuration
REQ-032 Macro PE_SAT_EN SHALL select output reduction in FORMAT.
REQ-033 With PE_SAT_EN defined: shifted value SHALL saturate to [-2^(WIDTH_DATA-1), 2^(WIDTH_DATA-1)-1]; without it: the low WIDTH_DATA bits SHALL be taken (wrap).

Structure
REQ-034 Package pe_pkg SHALL hold the state enum type and the saturate/truncate function.
REQ-035 Sub-module pe_mac_unit (product register + accumulator + clear, one lane) SHALL be instantiated NUM_LANES times via generate.

Verification (defaults except FRAC_BITS=0)
REQ-036 a={1,2,3,4}, b=3, len=2 -> outputs 6,12,18,24 on lanes 0,1,2,3, then IDLE.
REQ-037 len=2, all a=0x7FFF, b=0x7FFF (acc 0x7FFE0002) -> every lane 0x7FFF with PE_SAT_EN, 0x0002 without.
REQ-038 len=0 start -> four outputs of 0 after 3 cycles, busy_o high throughout.
REQ-039 out_ready_i low 5 cycles during lane 1 -> out_data_o/out_lane_o stable, no lane skipped or repeated.
REQ-040 rst asserted after 1 of 3 beats -> outputs 0 immediately; new job a={1,1,1,1}, b=2, len=1 -> four outputs of 2.
REQ-041 FRAC_BITS=8, a=-512, b=1, len=1 -> out_data_o=-2 (arithmetic shift) on every lane.

Source files
------------

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg -- shared types and helpers for the pe_mac_array block.
//
// Contents:
//   pe_state_e       control FSM state encoding (IDLE, RUN, FLUSH, FORMAT, DRAIN)
//   RED_W            working width of the output reduction helper
//   reduce_to_width  saturates a signed value to a WIDTH_DATA range when asked;
//                    otherwise passes it through so the caller keeps the low
//                    bits (wrap)
// -----------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_FORMAT,
        ST_DRAIN
    } pe_state_e;

    // Wide enough for any legal accumulator; callers sign-extend into it.
    localparam int unsigned RED_W = 64;

    // Returns the value clamped to [-2^(width-1), 2^(width-1)-1] when sat_en is
    // set. With sat_en clear the value is returned unchanged and the caller's
    // truncation to width bits performs the wrap.
    function automatic logic signed [RED_W-1:0] reduce_to_width(
        input logic signed [RED_W-1:0] value,
        input int unsigned             width,
        input logic                    sat_en
    );
        logic signed [RED_W-1:0] max_v;
        logic signed [RED_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (!sat_en) begin
            return value;
        end
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// -----------------------------------------------------------------------------
// pe_mac_unit -- one MAC lane: registered signed product followed by a
// wrapping accumulator.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   clear_i  synchronous clear of product and accumulator (job start)
//   beat_i   an operand beat is accepted this cycle
//   a_i      signed lane operand A
//   b_i      signed broadcast operand B
//   acc_o    signed accumulator, wraps modulo 2^WIDTH_ACC
// -----------------------------------------------------------------------------
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_ACC  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        beat_i,
    input  logic signed [WIDTH_DATA-1:0] a_i,
    input  logic signed [WIDTH_DATA-1:0] b_i,
    output logic signed [WIDTH_ACC-1:0]  acc_o
);

    localparam int PW = 2 * WIDTH_DATA;

    logic signed [PW-1:0]        prod_q, prod_d;
    logic                        prod_vld_q, prod_vld_d;
    logic signed [WIDTH_ACC-1:0] acc_q, acc_d;

    // Stage 1 registers the product of an accepted beat; stage 2 adds it the
    // following cycle, tracked by prod_vld so idle cycles add nothing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        prod_d     = prod_q;
        prod_vld_d = beat_i;
        acc_d      = acc_q;
        if (beat_i) begin
            prod_d = PW'(a_i) * PW'(b_i);
        end
        if (prod_vld_q) begin
            acc_d = acc_q + WIDTH_ACC'(prod_q);
        end
        if (clear_i) begin
            prod_d     = '0;
            prod_vld_d = 1'b0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_mac_array.sv
// -----------------------------------------------------------------------------
// pe_mac_array -- NUM_LANES parallel signed MAC lanes sharing a broadcast B
// operand, followed by fixed-point formatting and a lane-serial result drain.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   start_i       begins a job (sampled only in IDLE), len_i beats per job
//   in_valid_i    operand beat valid; accepted with in_ready_o (RUN only)
//   a_data_i      per-lane A, lane n at [n*WIDTH_DATA +: WIDTH_DATA]
//   b_data_i      operand B, broadcast to all lanes
//   out_valid_o   result valid; consumed with out_ready_i
//   out_data_o    formatted lane result, out_lane_o its lane index
//   busy_o        high in every state except IDLE
//
// Configuration: define PE_SAT_EN to saturate formatted results to the
// WIDTH_DATA range; by default the low WIDTH_DATA bits are kept (wrap).
// WIDTH_ACC must be at least 2*WIDTH_DATA.
// -----------------------------------------------------------------------------
module pe_mac_array
    import pe_pkg::*;
#(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_ACC  = 32,
    parameter int NUM_LANES  = 4,
    parameter int FRAC_BITS  = 8,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [15:0]                     len_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NUM_LANES*WIDTH_DATA-1:0] a_data_i,
    input  logic [WIDTH_DATA-1:0]           b_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [WIDTH_DATA-1:0]           out_data_o,
    output logic [LANE_W-1:0]               out_lane_o,
    output logic                            busy_o
);

`ifdef PE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    pe_state_e             state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [WIDTH_DATA-1:0] res_q [NUM_LANES];
    logic [WIDTH_DATA-1:0] res_d [NUM_LANES];
    logic [WIDTH_DATA-1:0] fmt   [NUM_LANES];
    logic signed [WIDTH_ACC-1:0] acc [NUM_LANES];

    logic clear;
    logic beat;

    assign beat = (state_q == ST_RUN) && in_valid_i;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        pe_mac_unit #(
            .WIDTH_DATA (WIDTH_DATA),
            .WIDTH_ACC  (WIDTH_ACC)
        ) u_mac (
            .clk     (clk),
            .rst     (rst),
            .clear_i (clear),
            .beat_i  (beat),
            .a_i     (a_data_i[l*WIDTH_DATA +: WIDTH_DATA]),
            .b_i     (b_data_i),
            .acc_o   (acc[l])
        );

        // Sign-extend before the shift so >>> is arithmetic at full width.
        assign fmt[l] = WIDTH_DATA'(reduce_to_width(
            RED_W'(acc[l]) >>> FRAC_BITS, WIDTH_DATA, SAT_EN));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        res_d   = res_q;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clear = 1'b1;
                    cnt_d = len_i;
                    state_d = (len_i != 16'd0) ? ST_RUN : ST_FLUSH;
                end
            end
            ST_RUN: begin
                if (in_valid_i) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // One cycle for the last registered product to reach the accumulator.
            ST_FLUSH: state_d = ST_FORMAT;
            ST_FORMAT: begin
                res_d   = fmt;
                lane_d  = '0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            // NOTE: the result registers are reset (not left uninitialised like
            // a memory) because out_data_o must read 0 straight out of reset.
            for (int l = 0; l < NUM_LANES; l++) begin
                res_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            res_q   <= res_d;
        end
    end

    assign in_ready_o  = (state_q == ST_RUN);
    assign out_valid_o = (state_q == ST_DRAIN);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_lane_o  = lane_q;
    assign out_data_o  = res_q[lane_q];

endmodule

// File: tb/tb_pe_mac_array.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_array -- self-checking bench. Two instances share stimulus: one
// with FRAC_BITS=0 and one with FRAC_BITS=8. Expected lane results come from a
// plain-arithmetic model of sum(a*b) and are queued at job issue; a monitor
// pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_pe_mac_array;

    localparam int W  = 16;
    localparam int NL = 4;

    typedef struct {
        logic [1:0]  lane;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [15:0]   len_i = '0;
    logic          in_valid_i = 1'b0;
    logic [NL*W-1:0] a_data_i = '0;
    logic [W-1:0]  b_data_i = '0;
    logic          out_ready_i = 1'b1;

    logic          in_ready0, out_valid0, busy0;
    logic [W-1:0]  out_data0;
    logic [1:0]    out_lane0;
    logic          in_ready8, out_valid8, busy8;
    logic [W-1:0]  out_data8;
    logic [1:0]    out_lane8;

    pe_mac_array #(.WIDTH_DATA(W), .WIDTH_ACC(32), .NUM_LANES(NL), .FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready0),
        .a_data_i(a_data_i), .b_data_i(b_data_i),
        .out_valid_o(out_valid0), .out_ready_i(out_ready_i),
        .out_data_o(out_data0), .out_lane_o(out_lane0), .busy_o(busy0)
    );

    pe_mac_array #(.WIDTH_DATA(W), .WIDTH_ACC(32), .NUM_LANES(NL), .FRAC_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready8),
        .a_data_i(a_data_i), .b_data_i(b_data_i),
        .out_valid_o(out_valid8), .out_ready_i(out_ready_i),
        .out_data_o(out_data8), .out_lane_o(out_lane8), .busy_o(busy8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    exp_t exp_q [2][$];

    // Current job operands, signed values.
    int ja [16][NL];
    int jb [16];

    int stall_left = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: wrapped 32-bit dot product, arithmetic shift, then 16-bit reduction.
    function automatic logic [15:0] model(input int frac, input int lane, input int len);
        longint sum = 0;
        int     acc32;
        int     sh;
        for (int i = 0; i < len; i++) begin
            sum += longint'(ja[i][lane]) * longint'(jb[i]);
        end
        acc32 = int'(sum);
        sh = acc32 >>> frac;
`ifdef PE_SAT_EN
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
`endif
        return 16'(sh);
    endfunction

    task automatic push_expect(input int len);
        exp_t e;
        for (int l = 0; l < NL; l++) begin
            e.lane = 2'(l);
            e.data = model(0, l, len);
            exp_q[0].push_back(e);
            e.data = model(8, l, len);
            exp_q[1].push_back(e);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic drive_beat(input int i);
        for (int l = 0; l < NL; l++) a_data_i[l*W +: W] = 16'(ja[i][l]);
        b_data_i = 16'(jb[i]);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (busy0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 300) check("idle_timeout", {63'd0, busy0}, 64'd0);
    endtask

    task automatic run_job(input int len, input bit gaps, input bit poke);
        int start_cyc;
        int budget;
        wait_idle();
        push_expect(len);
        start_i = 1'b1;
        len_i = 16'(len);
        start_cyc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i = 16'($urandom_range(65535));
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(2) == 0) begin
                in_valid_i = 1'b0;
                a_data_i = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            in_valid_i = 1'b1;
            drive_beat(i);
            check("in_ready_run", {63'd0, in_ready0}, 64'd1);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        budget = 0;
        while (!out_valid0 && budget < 20) begin
            check("busy_before_out", {63'd0, busy0}, 64'd1);
            check("in_ready_idle", {63'd0, in_ready0}, 64'd0);
            @(posedge clk); #1;
            budget++;
        end
        if (!gaps) check("latency", 64'(cyc - start_cyc), 64'(len + 3));
        if (budget >= 20) check("out_valid_timeout", {63'd0, out_valid0}, 64'd1);
        if (poke) begin
            // start_i and junk beats in DRAIN must change nothing.
            start_i = 1'b1;
            in_valid_i = 1'b1;
            a_data_i = {$urandom, $urandom};
            b_data_i = 16'($urandom);
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        wait_idle();
        in_valid_i = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_busy0", {63'd0, busy0}, 64'd0);
        check("rst_in_ready0", {63'd0, in_ready0}, 64'd0);
        check("rst_out_valid0", {63'd0, out_valid0}, 64'd0);
        check("rst_out_data0", {48'd0, out_data0}, 64'd0);
        check("rst_out_lane0", {62'd0, out_lane0}, 64'd0);
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_out_valid8", {63'd0, out_valid8}, 64'd0);
        check("rst_out_data8", {48'd0, out_data8}, 64'd0);
    endtask

    // Output ready driver.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && out_valid0 && out_lane0 == 2'd1) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                out_ready_i = ($urandom_range(3) != 0);
            end else begin
                out_ready_i = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    bit          prev_stall [2];
    logic [15:0] prev_data  [2];
    logic [1:0]  prev_lane  [2];

    task automatic monitor_port(input int id, input logic v, input logic [1:0] lane,
                                input logic [15:0] data);
        exp_t e;
        if (prev_stall[id]) begin
            check($sformatf("hold_valid%0d", id), {63'd0, v}, 64'd1);
            check($sformatf("hold_data%0d", id), {48'd0, data}, {48'd0, prev_data[id]});
            check($sformatf("hold_lane%0d", id), {62'd0, lane}, {62'd0, prev_lane[id]});
        end
        if (v && out_ready_i) begin
            if (exp_q[id].size() == 0) begin
                check($sformatf("unexpected_out%0d", id), {63'd0, v}, 64'd0);
            end else begin
                e = exp_q[id].pop_front();
                check($sformatf("data%0d_lane%0d", id, e.lane), {48'd0, data}, {48'd0, e.data});
                check($sformatf("lane%0d", id), {62'd0, lane}, {62'd0, e.lane});
            end
        end
        prev_stall[id] = v && !out_ready_i;
        prev_data[id]  = data;
        prev_lane[id]  = lane;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall[0] = 1'b0;
                prev_stall[1] = 1'b0;
            end else begin
                monitor_port(0, out_valid0, out_lane0, out_data0);
                monitor_port(1, out_valid8, out_lane8, out_data8);
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;

        // a={1,2,3,4}, b=3, two beats.
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < NL; l++) ja[i][l] = l + 1;
            jb[i] = 3;
        end
        run_job(2, 1'b0, 1'b0);

        // Large positive accumulator: saturation vs wrap.
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < NL; l++) ja[i][l] = 32767;
            jb[i] = 32767;
        end
        run_job(2, 1'b0, 1'b0);

        // Zero-length job.
        run_job(0, 1'b0, 1'b0);

        // Five-cycle back-pressure on lane 1.
        for (int i = 0; i < 3; i++) begin
            for (int l = 0; l < NL; l++) ja[i][l] = rnd16();
            jb[i] = rnd16();
        end
        stall_left = 5;
        run_job(3, 1'b0, 1'b0);
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Arithmetic shift of a negative accumulator.
        for (int l = 0; l < NL; l++) ja[0][l] = -512;
        jb[0] = 1;
        run_job(1, 1'b0, 1'b0);

        // Randomised jobs with input gaps, random back-pressure, DRAIN pokes.
        rand_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                for (int l = 0; l < NL; l++) ja[i][l] = rnd16();
                jb[i] = rnd16();
            end
            run_job(len, (j % 2) == 1, (j % 3) == 0);
        end
        rand_ready = 1'b0;
        wait_idle();

        // Reset after one of three beats discards the job.
        for (int l = 0; l < NL; l++) ja[0][l] = 100 + l;
        jb[0] = 7;
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i = 16'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        in_valid_i = 1'b1;
        drive_beat(0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid_i = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int l = 0; l < NL; l++) ja[0][l] = 1;
        jb[0] = 2;
        run_job(1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue0_drained", 64'(exp_q[0].size()), 64'd0);
        check("queue8_drained", 64'(exp_q[1].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
